// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if -- bundle of every mem_port_arb signal except clk/rst.
//
// Groups:
//   m0_* / m1_*   two requesting masters: req/we/addr/wdata in, gnt/rvalid/rdata out
//   mem_*         single-word memory port (CPU_addr/CPU_wdata/CPU_wenable/CPU_rdata/CPU_ready)
//   busy          arbiter is not idle
//   timeout_err   one-cycle pulse when a read is abandoned
//
// Modports:
//   slave   the arbiter's view
//   master  the view of whatever drives the masters and the memory (testbench or top level)
interface mem_port_arb_if #(
    parameter int WORDSIZE = 16
);
    logic                m0_req;
    logic                m0_we;
    logic [WORDSIZE-1:0] m0_addr;
    logic [WORDSIZE-1:0] m0_wdata;
    logic                m0_gnt;
    logic                m0_rvalid;
    logic [WORDSIZE-1:0] m0_rdata;

    logic                m1_req;
    logic                m1_we;
    logic [WORDSIZE-1:0] m1_addr;
    logic [WORDSIZE-1:0] m1_wdata;
    logic                m1_gnt;
    logic                m1_rvalid;
    logic [WORDSIZE-1:0] m1_rdata;

    logic [WORDSIZE-1:0] mem_addr;
    logic [WORDSIZE-1:0] mem_wdata;
    logic                mem_wenable;
    logic [WORDSIZE-1:0] mem_rdata;
    logic                mem_ready;

    logic                busy;
    logic                timeout_err;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata, mem_ready,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_wenable,
        output busy, timeout_err
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata, mem_ready,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_wenable,
        input  busy, timeout_err
    );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb -- two-master round-robin arbiter and access sequencer for the
// mmu CPU data port. Master 0 is the CPU core, master 1 the block-copy/DMA
// engine. One single-word access is in flight at a time; the memory port is
// driven from registers, reads wait for mem_ready and the data is returned to
// the owning master with a one-cycle rvalid pulse.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   mem_port_arb_if.slave: m0_*/m1_* master handshakes, mem_* memory
//         port, busy, timeout_err
//
// Parameters:
//   WORDSIZE  data/address width
//   TIMEOUT   WAIT cycles before a read is abandoned (watchdog builds only)
//   ERR_WORD  read data returned on a timeout
//
// Build option:
//   MEM_PORT_ARB_TIMEOUT_EN  when defined, a WAIT-state watchdog abandons reads
//                            after TIMEOUT cycles without mem_ready; when
//                            undefined, WAIT holds until mem_ready and
//                            timeout_err stays 0.
module mem_port_arb #(
    parameter int                  WORDSIZE = 16,
    parameter int                  TIMEOUT  = 15,
    parameter logic [WORDSIZE-1:0] ERR_WORD = WORDSIZE'(16'hDEAD)
) (
    input logic           clk,
    input logic           rst,
    mem_port_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     last_q, last_d;      // last granted master; also owner of the access in flight
    logic [1:0]               gnt_q, gnt_d;
    logic [1:0]               rvalid_q, rvalid_d;
    logic [1:0][WORDSIZE-1:0] rdata_q, rdata_d;
    logic [WORDSIZE-1:0]      mem_addr_q, mem_addr_d;
    logic [WORDSIZE-1:0]      mem_wdata_q, mem_wdata_d;
    logic                     mem_we_q, mem_we_d;
    logic                     tmo_q, tmo_d;

    logic [1:0]               req;
    logic [1:0]               we;
    logic [1:0][WORDSIZE-1:0] addr;
    logic [1:0][WORDSIZE-1:0] wdata;
    logic                     win;
    logic                     tmo_hit;             // WAIT is giving up on this cycle

    assign req   = {bus.m1_req,   bus.m0_req};
    assign we    = {bus.m1_we,    bus.m0_we};
    assign addr  = {bus.m1_addr,  bus.m0_addr};
    assign wdata = {bus.m1_wdata, bus.m0_wdata};

    // Lone requester wins; on a tie the master that was not granted last wins.
    assign win = req[1] & (~req[0] | ~last_q);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts completed no-ready WAIT cycles; the cycle that would take it
    // to TIMEOUT is the one that abandons. A ready in that cycle still wins.
    assign tmo_hit = !bus.mem_ready && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT && !bus.mem_ready && !tmo_hit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;                         // write strobe lives only in ISSUE
        tmo_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    mem_addr_d  = addr[win];
                    mem_wdata_d = wdata[win];
                    mem_we_d    = we[win];
                    gnt_d[win]  = 1'b1;
                    last_d      = win;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = mem_we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (bus.mem_ready || tmo_hit) begin
                    rdata_d[last_q]  = bus.mem_ready ? bus.mem_rdata : ERR_WORD;
                    rvalid_d[last_q] = 1'b1;
                    tmo_d            = tmo_hit;
                    state_d          = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;                    // master 0 wins the first tie
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.m0_gnt      = gnt_q[0];
    assign bus.m1_gnt      = gnt_q[1];
    assign bus.m0_rvalid   = rvalid_q[0];
    assign bus.m1_rvalid   = rvalid_q[1];
    assign bus.m0_rdata    = rdata_q[0];
    assign bus.m1_rdata    = rdata_q[1];
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_wenable = mem_we_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb -- self-checking bench for mem_port_arb. Read results go
// through a scoreboard: the expected owner/data/error is queued when a read
// request is driven and popped by a negedge monitor on every rvalid. Each
// scenario task also checks cycle timing inline. Inputs change #1 after the
// rising edge; outputs are sampled there or at the falling edge.
`timescale 1ns/1ps
module tb_mem_port_arb;
    localparam int W = 16;

    typedef struct packed {
        logic         m;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arb_if #(.WORDSIZE(W)) bus ();

    mem_port_arb #(
        .WORDSIZE(W),
        .TIMEOUT (15),
        .ERR_WORD(16'hDEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory model: fixed word, or a function of the address so that reads
    // from different masters return distinguishable data.
    logic         use_fixed = 1'b0;
    logic [W-1:0] fixed_rdata = '0;
    assign bus.mem_rdata = use_fixed ? fixed_rdata : (bus.mem_addr ^ 16'hA5A5);

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic         mon_m;
    logic [W-1:0] mon_d;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m0_gnt && bus.m1_gnt) begin
                vectors++; miscompares++;
                $display("FAIL dual_gnt: both gnt high at %0t", $time);
            end
            if (bus.timeout_err && !(bus.m0_rvalid || bus.m1_rvalid)) begin
                vectors++; miscompares++;
                $display("FAIL lone_timeout_err: timeout_err without rvalid at %0t", $time);
            end
            if (bus.m0_rvalid && bus.m1_rvalid) begin
                vectors++; miscompares++;
                $display("FAIL dual_rvalid: both rvalid high at %0t", $time);
            end else if (bus.m0_rvalid || bus.m1_rvalid) begin
                mon_m = bus.m1_rvalid;
                mon_d = mon_m ? bus.m1_rdata : bus.m0_rdata;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rvalid: m%0d data %h at %0t, none expected", mon_m, mon_d, $time);
                end else begin
                    mon_e = sb.pop_front();
                    if ({mon_m, mon_d, bus.timeout_err} !== {mon_e.m, mon_e.data, mon_e.err}) begin
                        miscompares++;
                        $display("FAIL sb_read: got m%0d data %h err %b, expected m%0d data %h err %b",
                                 mon_m, mon_d, bus.timeout_err, mon_e.m, mon_e.data, mon_e.err);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        vectors++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_wenable, bus.busy, bus.timeout_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: gnt/rvalid/we/busy/err = %b, expected 0",
                     {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_wenable, bus.busy, bus.timeout_err});
        end
        vectors++;
        if ({bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h wdata %h rdata0 %h rdata1 %h, expected 0",
                     bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        use_fixed = 1'b1; fixed_rdata = 16'h1234; bus.mem_ready = 1'b1;   // ready in ISSUE must be ignored
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0010;
        sb.push_back('{m: 1'b0, data: 16'h1234, err: 1'b0});
        tick();                                                          // cycle 1
        vectors++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.mem_wenable, bus.busy} !== 4'b1001 || bus.mem_addr !== 16'h0010) begin
            miscompares++;
            $display("FAIL read_gnt: gnt0 %b gnt1 %b we %b busy %b addr %h, expected 1 0 0 1 0010",
                     bus.m0_gnt, bus.m1_gnt, bus.mem_wenable, bus.busy, bus.mem_addr);
        end
        bus.m0_req = 1'b0;
        tick();                                                          // cycle 2, WAIT
        vectors++;
        if (bus.m0_rvalid !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_early: rvalid %b busy %b in cycle 2, expected 0 1", bus.m0_rvalid, bus.busy);
        end
        tick();                                                          // cycle 3
        vectors++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL read_data: rvalid %b rdata %h in cycle 3, expected 1 1234", bus.m0_rvalid, bus.m0_rdata);
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.m0_rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL read_idle: busy %b rdata %h, expected 0 1234 held", bus.busy, bus.m0_rdata);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_single_write();
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 16'h0C05; bus.m1_wdata = 16'hBEEF;
        tick();                                                          // cycle 1
        vectors++;
        if ({bus.m1_gnt, bus.m0_gnt, bus.mem_wenable} !== 3'b101 || bus.mem_addr !== 16'h0C05 || bus.mem_wdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL write_issue: gnt1 %b gnt0 %b we %b addr %h wdata %h, expected 1 0 1 0c05 beef",
                     bus.m1_gnt, bus.m0_gnt, bus.mem_wenable, bus.mem_addr, bus.mem_wdata);
        end
        bus.m1_req = 1'b0;
        tick();                                                          // cycle 2
        vectors++;
        if (bus.mem_wenable !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 16'h0C05 || bus.m1_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL write_done: we %b busy %b addr %h gnt1 %b, expected 0 0 0c05 0",
                     bus.mem_wenable, bus.busy, bus.mem_addr, bus.m1_gnt);
        end
    endtask

    task automatic test_tie();
        int got;
        do_reset();
        use_fixed = 1'b0; bus.mem_ready = 1'b1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0100;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0200;
        for (int g = 0; g < 4; g++) begin
            sb.push_back('{m: g[0], data: (g[0] ? 16'h0200 : 16'h0100) ^ 16'hA5A5, err: 1'b0});
        end
        for (int g = 0; g < 4; g++) begin
            got = -1;
            for (int c = 0; c < 6 && got < 0; c++) begin
                tick();
                if (bus.m0_gnt) got = 0;
                else if (bus.m1_gnt) got = 1;
            end
            vectors++;
            if (got != (g % 2)) begin
                miscompares++;
                $display("FAIL tie_order: grant %0d went to %0d, expected %0d", g, got, g % 2);
            end
            if (g == 3) begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b0;
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_withdraw_and_reset();
        int bad;
        // Withdrawn request while busy is never served.
        use_fixed = 1'b0; bus.mem_ready = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0300;
        sb.push_back('{m: 1'b0, data: 16'h0300 ^ 16'hA5A5, err: 1'b0});
        tick();
        vectors++;
        if (bus.m0_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL withdraw_gnt0: gnt0 %b, expected 1", bus.m0_gnt);
        end
        bus.m0_req = 1'b0;
        tick();
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0400;
        tick();
        bus.m1_req = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        vectors++;
        if (bus.m0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL withdraw_rvalid: rvalid0 %b, expected 1", bus.m0_rvalid);
        end
        bad = 0;
        repeat (4) begin
            tick();
            if (bus.m1_gnt !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL withdraw_m1: m1_gnt seen %0d times, expected 0", bad);
        end

        // Reset in WAIT drops the read.
        bus.mem_ready = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0500;
        tick();
        bus.m0_req = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: busy %b before reset, expected 1", bus.busy);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_wenable, bus.busy, bus.timeout_err} !== 7'b0 ||
            {bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rst_wait: ctl %b addr %h wdata %h rdata0 %h rdata1 %h, expected all 0",
                     {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_wenable, bus.busy, bus.timeout_err},
                     bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata);
        end
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        bad = 0;
        repeat (4) begin
            tick();
            if (bus.m0_rvalid !== 1'b0 || bus.m0_gnt !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rst_drop: activity after reset in %0d cycles, expected none", bad);
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int gnts, prev, bad;
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 16'h0011; bus.m0_wdata = 16'h1111;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 16'h0022; bus.m1_wdata = 16'h2222;
        gnts = 0; prev = -1; bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.m0_gnt || bus.m1_gnt) begin
                gnts++;
                if (int'(bus.m1_gnt) == prev) bad++;
                prev = int'(bus.m1_gnt);
                if (bus.mem_wenable !== 1'b1 || bus.mem_wdata !== (bus.m1_gnt ? 16'h2222 : 16'h1111)) bad++;
            end else if (bus.mem_wenable !== 1'b0) begin
                bad++;
            end
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        vectors++;
        if (gnts != 3) begin
            miscompares++;
            $display("FAIL b2b_rate: %0d grants in 6 cycles, expected 3", gnts);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL b2b_alt: %0d alternation/strobe errors, expected 0", bad);
        end
        tick();
        tick();
    endtask

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        // Ready never arrives: abandoned after 15 WAIT cycles.
        bus.mem_ready = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0600;
        sb.push_back('{m: 1'b0, data: 16'hDEAD, err: 1'b1});
        tick();
        bus.m0_req = 1'b0;
        bad = 0;
        repeat (15) begin
            tick();
            if (bus.m0_rvalid !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL tmo_early: %0d bad cycles before limit, expected 0", bad);
        end
        tick();
        vectors++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'hDEAD || bus.timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_hit: rvalid %b rdata %h err %b, expected 1 dead 1",
                     bus.m0_rvalid, bus.m0_rdata, bus.timeout_err);
        end
        tick();
        vectors++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_after: err %b busy %b, expected 0 0", bus.timeout_err, bus.busy);
        end

        // Ready on the 15th WAIT cycle beats the limit.
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0700;
        sb.push_back('{m: 1'b0, data: 16'h0700 ^ 16'hA5A5, err: 1'b0});
        tick();
        bus.m0_req = 1'b0;
        repeat (14) tick();
        tick();
        bus.mem_ready = 1'b1;
        tick();
        vectors++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== (16'h0700 ^ 16'hA5A5) || bus.timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_ready_wins: rvalid %b rdata %h err %b, expected 1 %h 0",
                     bus.m0_rvalid, bus.m0_rdata, bus.timeout_err, 16'h0700 ^ 16'hA5A5);
        end
        bus.mem_ready = 1'b0;
        tick();
    endtask
`else
    task automatic test_long_wait();
        int bad;
        bus.mem_ready = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0800;
        sb.push_back('{m: 1'b0, data: 16'h0800 ^ 16'hA5A5, err: 1'b0});
        tick();
        bus.m0_req = 1'b0;
        bad = 0;
        repeat (100) begin
            tick();
            if (bus.busy !== 1'b1 || bus.m0_rvalid !== 1'b0 || bus.timeout_err !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL long_wait: %0d bad cycles while waiting, expected 0", bad);
        end
        bus.mem_ready = 1'b1;
        tick();
        vectors++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== (16'h0800 ^ 16'hA5A5)) begin
            miscompares++;
            $display("FAIL long_ready: rvalid %b rdata %h, expected 1 %h", bus.m0_rvalid, bus.m0_rdata, 16'h0800 ^ 16'hA5A5);
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.m0_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL long_single: busy %b rvalid %b, expected 0 0", bus.busy, bus.m0_rvalid);
        end
        bus.mem_ready = 1'b0;
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_tie();
        test_withdraw_and_reset();
        test_back_to_back();
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d reads never returned, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-master arbiter and access sequencer for the `mmu` CPU data port (`CPU_addr`/`CPU_wdata`/`CPU_wenable`/`CPU_rdata`/`CPU_ready`). Master 0 is the CPU core and master 1 is the block-copy/DMA engine. The arbiter accepts one single-word access at a time and grants by round-robin. It drives the memory port from registers, waits for read completion, and returns read data to the owning master with a one-cycle valid pulse.

## Interface
- `WORDSIZE`, 16, data and address width
- `TIMEOUT`, 15, maximum cycles in WAIT before a read is abandoned; only used with `MEM_PORT_ARB_TIMEOUT_EN`
- `ERR_WORD`, 16'hDEAD, read data returned on timeout
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mN_req`  in  1  master N (N=0,1) requests an access; held with `mN_we`/`mN_addr`/`mN_wdata` stable until `mN_gnt`; may be withdrawn before grant
- `mN_we`  in  1  1 = write, 0 = read
- `mN_addr`  in  WORDSIZE  word address (mmu CPU address map)
- `mN_wdata`  in  WORDSIZE  write data
- `mN_gnt`  out  1  one-cycle pulse: request accepted and captured
- `mN_rvalid`  out  1  one-cycle pulse: `mN_rdata` valid
- `mN_rdata`  out  WORDSIZE  read data, held until next rvalid to that master
- `mem_addr`  out  WORDSIZE  to `CPU_addr`
- `mem_wdata`  out  WORDSIZE  to `CPU_wdata`
- `mem_wenable`  out  1  to `CPU_wenable`
- `mem_rdata`  in  WORDSIZE  from `CPU_rdata`
- `mem_ready`  in  1  from `CPU_ready`
- `busy`  out  1  high whenever state is not IDLE
- `timeout_err`  out  1  one-cycle pulse on abandoned read

## Operation
- States: IDLE, ISSUE, WAIT. Reset puts the block in IDLE.
- Reset values: all outputs 0, `last` = 1 (so master 0 wins the first tie), timeout counter 0.
- IDLE:
  - If exactly one `req` is high, that master wins.
  - If both are high, the master ≠ `last` wins.
  - On the edge: register the winner's addr/wdata/we into `mem_*` (`mem_wenable` = we), pulse the winner's `gnt`, set `last` = winner, and go to ISSUE.
- ISSUE (always one cycle; memory sees the access):
  - Write: deassert `mem_wenable` and return to IDLE.
  - Read: go to WAIT.
- WAIT:
  - When `mem_ready`=1, capture `mem_rdata` into the owner's `rdata`, pulse the owner's `rvalid`, and go to IDLE.
  - `mem_addr` is held unchanged throughout WAIT.
- `mem_addr`/`mem_wdata` hold their last value in IDLE; only `mem_wenable` is forced to 0 outside ISSUE.
- Withdrawn request: a `req` dropped before `gnt` is never served. A request already granted always completes.
- The winner's `req` may stay high after `gnt`; it is treated as a new request at the next IDLE.
- The non-owner's `req` is ignored (not queued) while `busy`.
- Under continuous requests from both masters, grants strictly alternate.
- `rst` asserted in any state returns to IDLE on that edge. An in-flight read is dropped: no `rvalid` and no `gnt` for it.

## Timing
- Request sampled in IDLE at edge k gives `gnt` and `mem_*` valid during cycle k+1.
- Write: `mem_wenable` is high for exactly cycle k+1. Back in IDLE at k+2. Next grant earliest at edge k+2, so one write per 2 cycles.
- Read: WAIT is entered at k+2. If `mem_ready` is high in cycle k+2, `rvalid` and `rdata` appear in cycle k+3. Minimum read-to-read spacing is 3 cycles.
- `mem_ready` is only sampled in WAIT. Its value in IDLE and ISSUE is ignored.
- `gnt` and `rvalid` never pulse for both masters in the same cycle.

## Configuration
- `MEM_PORT_ARB_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments each WAIT cycle with `mem_ready`=0.
  - When it reaches `TIMEOUT` without ready, the owner gets `rvalid` with `rdata` = `ERR_WORD`, `timeout_err` pulses, and the state returns to IDLE.
  - `mem_ready` in the same cycle as the limit wins: real data is returned and there is no error.
- Undefined: no counter; WAIT holds until `mem_ready`. `timeout_err` is tied 0.

## Test plan
- **Single read.** m0 reads 0x0010 with `mem_ready` high in the first WAIT cycle and `mem_rdata`=0x1234.
  - Expect `m0_gnt` in cycle 1 and `m0_rvalid` with 0x1234 in cycle 3.
- **Single write.** m1 writes 0xBEEF to 0x0C05.
  - Expect `mem_wenable` high for one cycle with `mem_addr`=0x0C05 and `mem_wdata`=0xBEEF, `m1_gnt` pulsed, `busy` low by cycle 2.
- **Tie after reset.** Both masters hold `req` for reads.
  - Expect grant order m0, m1, m0, m1, and each `rvalid` goes only to its owner.
- **Withdraw and reset mid-read.**
  - m1 drops `req` before grant: expect no `m1_gnt`.
  - `rst` pulsed in WAIT: expect IDLE next cycle, all outputs 0, no `rvalid`.
- **Timeout** (macro defined, TIMEOUT=15). Keep `mem_ready` low.
  - Expect `m0_rvalid` with 0xDEAD and `timeout_err` after 15 WAIT cycles.
  - Repeat with `mem_ready` high on the 15th WAIT cycle: expect real data and no error.
- **Macro undefined.** Hold `mem_ready` low for 100 cycles, then raise it.
  - Expect `busy` held throughout and a single `rvalid` after ready.
